// File: rtl/audio_aes_pkg.sv
// Shared definitions for the audio-to-AES block sequencer: sequencer states
// and the default block geometry.
package audio_aes_pkg;

    localparam int BYTES_PER_BLOCK_DEFAULT = 16;
    localparam int DATA_W_DEFAULT          = 8;
    localparam int CNT_W_DEFAULT           = 16;
    localparam int BLOCK_W                 = BYTES_PER_BLOCK_DEFAULT * DATA_W_DEFAULT;
    localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h00;

    typedef enum logic [2:0] {
        S_COLLECT = 3'd0,
        S_PAD     = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_OUT     = 3'd4
    } seq_state_t;

endpackage

// File: rtl/byte_block_packer.sv
// Packs bytes into a cipher block, first byte in the most significant lane.
// Pad bytes enter through the same shift path so a short block is filled
// exactly like a full one. next_full flags that the next shift completes it.
module byte_block_packer
    import audio_aes_pkg::*;
#(
    parameter int NBYTES = BYTES_PER_BLOCK_DEFAULT,
    parameter int DW = DATA_W_DEFAULT,
    parameter logic [DW-1:0] PAD = PAD_BYTE_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            byte_en,
    input  logic [DW-1:0]                   byte_in,
    input  logic                            pad_en,
    output logic [NBYTES*DW-1:0]            block,
    output logic [$clog2(NBYTES+1)-1:0]     count,
    output logic                            next_full
);

    localparam int BW = NBYTES * DW;
    localparam int CW = $clog2(NBYTES + 1);

    // Shift one byte (data or pad) in at the bottom; clear empties the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block <= '0;
            count <= '0;
        end else if (clear) begin
            block <= '0;
            count <= '0;
        end else if (byte_en || pad_en) begin
            block <= {block[BW-DW-1:0], (byte_en ? byte_in : PAD)};
            count <= count + CW'(1);
        end
    end

    // The block becomes full on the shift taken while this is high.
    always_comb begin
        next_full = (count == CW'(NBYTES - 1));
    end

endmodule

// File: rtl/audio_block_sequencer.sv
// Collects audio bytes into cipher blocks (zero-padding a short final block),
// launches the AES core with a one-cycle start, waits for done and offers the
// ciphertext downstream.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. A source holds data stable while valid is high and ready is low;
// ready never depends combinationally on valid.
module audio_block_sequencer
    import audio_aes_pkg::*;
#(
    parameter int BYTES_PER_BLOCK = BYTES_PER_BLOCK_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0] PAD_BYTE = PAD_BYTE_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DATA_W-1:0]                   in_data,
    input  logic                                in_valid,
    input  logic                                in_last,
    output logic                                in_ready,
    output logic                                aes_start,
    output logic [BYTES_PER_BLOCK*DATA_W-1:0]   aes_block_in,
    input  logic                                aes_done,
    input  logic [BYTES_PER_BLOCK*DATA_W-1:0]   aes_block_out,
    output logic [BYTES_PER_BLOCK*DATA_W-1:0]   out_block,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last,
    output logic [CNT_W-1:0]                    blk_count,
    output logic                                busy,
    output logic [2:0]                          state_dbg
);

    localparam int CW = $clog2(BYTES_PER_BLOCK + 1);

    seq_state_t    state, nxt;
    logic          run_q;
    logic          last_q;
    logic          byte_en;
    logic          pad_en;
    logic          clear;
    logic [CW-1:0] pk_count;
    logic          pk_next_full;

    byte_block_packer #(
        .NBYTES (BYTES_PER_BLOCK),
        .DW     (DATA_W),
        .PAD    (PAD_BYTE)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .byte_en   (byte_en),
        .byte_in   (in_data),
        .pad_en    (pad_en),
        .block     (aes_block_in),
        .count     (pk_count),
        .next_full (pk_next_full)
    );

    // Status outputs decode registered state only; run_q keeps in_ready low
    // until the first clock after reset release.
    always_comb begin
        in_ready  = run_q && (state == S_COLLECT);
        aes_start = (state == S_START);
        out_valid = (state == S_OUT);
        out_last  = (state == S_OUT) && last_q;
        busy      = !((state == S_COLLECT) && (pk_count == '0));
        state_dbg = state;
    end

    // Next-state and packer control.
    always_comb begin
        nxt     = state;
        byte_en = 1'b0;
        pad_en  = 1'b0;
        clear   = 1'b0;
        case (state)
            S_COLLECT: begin
                if (in_valid && in_ready) begin
                    byte_en = 1'b1;
                    if (pk_next_full)  nxt = S_START;
                    else if (in_last)  nxt = S_PAD;
                end
            end
            S_PAD: begin
                pad_en = 1'b1;
                if (pk_next_full) nxt = S_START;
            end
            S_START: nxt = S_WAIT;
            S_WAIT: begin
                if (aes_done) nxt = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    clear = 1'b1;
                    nxt   = S_COLLECT;
                end
            end
            default: nxt = S_COLLECT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_COLLECT;
        else        state <= nxt;
    end

    // Goes high on the first clock after reset release and stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    // Remember that the stream ended inside the current block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   last_q <= 1'b0;
        else if (clear)               last_q <= 1'b0;
        else if (byte_en && in_last)  last_q <= 1'b1;
    end

    // Capture the ciphertext only while waiting on the core; strays are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              out_block <= '0;
        else if ((state == S_WAIT) && aes_done)  out_block <= aes_block_out;
    end

    // Count delivered blocks; wraps naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     blk_count <= '0;
        else if (clear) blk_count <= blk_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_audio_block_sequencer.sv
// Bench for audio_block_sequencer: directed scenarios followed by randomized
// streams, checked against a block-level reference (bytes grouped into blocks,
// zero padded, ciphertext = inverted plaintext from the AES stand-in).
module tb_audio_block_sequencer;
    import audio_aes_pkg::*;

    // Narrow counter so the wrap-around is reached in a short run.
    localparam int TB_CNT_W = 5;
    localparam int BW = BLOCK_W;

    // ---------------- clock / reset ----------------
    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [7:0]          in_data;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic                aes_start;
    logic [BW-1:0]       aes_block_in;
    logic                aes_done;
    logic [BW-1:0]       aes_block_out;
    logic [BW-1:0]       out_block;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [TB_CNT_W-1:0] blk_count;
    logic                busy;
    logic [2:0]          state_dbg;

    always #5 clk = ~clk;

    audio_block_sequencer #(.CNT_W(TB_CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .aes_start     (aes_start),
        .aes_block_in  (aes_block_in),
        .aes_done      (aes_done),
        .aes_block_out (aes_block_out),
        .out_block     (out_block),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .blk_count     (blk_count),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [BW:0]   exp_q[$];      // {last, ciphertext} in delivery order
    logic [BW-1:0] pt_q[$];       // plaintext expected at each aes_start
    logic [8:0]    tx_q[$];       // {last, byte} to drive
    int            exp_blocks = 0;
    int            exp_cnt = 0;
    logic [BW-1:0] last_exp_blk = '0;
    int            aes_lat = 10;
    bit            lat_rand = 1'b0;
    int            stray_req = 0;
    bit            sink_rand = 1'b0;
    logic          sink_force = 1'b0;

    task automatic check_val(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Build the byte stream and its expected blocks from the stream rules.
    task automatic queue_stream(input int n, input bit lst, input int base, input bit expect_out);
        logic [7:0]    b[$];
        logic [BW-1:0] blk;
        int            n_in;
        for (int i = 0; i < n; i++) begin
            b.push_back(base >= 0 ? 8'(base + i) : 8'($urandom));
            tx_q.push_back({(lst && (i == n - 1)), b[i]});
        end
        for (int i = 0; i < n; i += 16) begin
            n_in = (n - i < 16) ? (n - i) : 16;
            blk = '0;
            for (int j = 0; j < 16; j++)
                blk[BW-1-8*j -: 8] = (j < n_in) ? b[i+j] : PAD_BYTE_DEFAULT;
            pt_q.push_back(blk);
            if (expect_out) begin
                exp_q.push_back({(lst && (i + 16 >= n)), ~blk});
                exp_blocks++;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Returns on the negedge of the cycle after the last byte was accepted.
    task automatic drive_tx(input bit gaps);
        logic [8:0] it;
        int         guard;
        int         r;
        while (tx_q.size() != 0) begin
            it = tx_q.pop_front();
            if (gaps) begin
                r = $urandom_range(0, 2);
                repeat (r) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = it[7:0];
            in_last  = it[8];
            guard = 0;
            while (!in_ready && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 500) begin
                check_val("in_ready_timeout", 0, 1);
                tx_q.delete();
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            check_val("drain_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    // ---------------- AES stand-in: done after a latency, result = ~plaintext ----------------
    initial begin : aes_model
        int            stray_ack = 0;
        bit            pending = 1'b0;
        int            timer = 0;
        logic [BW-1:0] cap = '0;
        logic          prev_start = 1'b0;
        aes_done = 1'b0;
        aes_block_out = '0;
        forever begin
            @(negedge clk);
            aes_done = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
                prev_start = 1'b0;
            end else begin
                if (pending) begin
                    if (timer == 0) begin
                        aes_done = 1'b1;
                        aes_block_out = ~cap;
                        pending = 1'b0;
                    end else begin
                        timer--;
                    end
                end else if (stray_ack != stray_req) begin
                    aes_done = 1'b1;
                    aes_block_out = {4{$urandom}};
                    stray_ack = stray_req;
                end
                if (aes_start) begin
                    check_val("start_pulse", prev_start, 0);
                    if (pt_q.size() == 0) check_val("unexpected_start", 1, 0);
                    else check_val("aes_block_in", aes_block_in, pt_q.pop_front());
                    cap = aes_block_in;
                    pending = 1'b1;
                    timer = (lat_rand ? $urandom_range(1, 12) : aes_lat) - 1;
                end
                prev_start = aes_start;
            end
        end
    end

    // ---------------- output sink and block checker ----------------
    initial begin : sink
        logic        pv = 1'b0;
        logic        pr = 1'b0;
        logic [BW:0] e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_cnt = 0;
                pv = 1'b0;
                out_ready = 1'b0;
            end else begin
                check_val("blk_count", blk_count, exp_cnt % (1 << TB_CNT_W));
                if (pv && !pr) check_val("valid_held", out_valid, 1);
                out_ready = sink_rand ? ($urandom_range(0, 2) != 0) : sink_force;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_block", 1, 0);
                    end else begin
                        e = exp_q[0];
                        check_val("out_block", out_block, e[BW-1:0]);
                        check_val("out_last", out_last, e[BW]);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            last_exp_blk = e[BW-1:0];
                            exp_cnt++;
                        end
                    end
                end
                pv = out_valid;
                pr = out_ready;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #500000;
        check_val("watchdog", 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int  k;
        int  n;
        bit  lst;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_aes_start", aes_start, 0);
        check_val("rst_aes_block_in", aes_block_in, 0);
        check_val("rst_out_block", out_block, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_blk_count", blk_count, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_state", state_dbg, S_COLLECT);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_val("ready_after_reset", in_ready, 1);

        // Full block 00..0F, output held back for a while.
        sink_force = 1'b0;
        queue_stream(16, 1'b0, 0, 1'b1);
        drive_tx(1'b0);
        check_val("t1_start", aes_start, 1);
        check_val("t1_block_in", aes_block_in, 128'h000102030405060708090A0B0C0D0E0F);
        check_val("t1_in_ready", in_ready, 0);
        check_val("t1_busy", busy, 1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) check_val("t1_start_drop", aes_start, 0);
            check_val("t1_no_valid_yet", out_valid, 0);
            check_val("t1_in_ready_wait", in_ready, 0);
        end
        @(negedge clk);
        check_val("t1_valid_at_d1", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) stray_req++;
            check_val("t1_stall_valid", out_valid, 1);
            check_val("t1_stall_count", blk_count, 0);
            check_val("t1_stall_in_ready", in_ready, 0);
        end
        sink_force = 1'b1;
        wait_drain();

        // Short final block A0..AC: three pad cycles, last flag set.
        queue_stream(13, 1'b1, 8'hA0, 1'b1);
        drive_tx(1'b0);
        k = 0;
        while (!aes_start && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_val("t2_pad_cycles", k, 3);
        check_val("t2_block_in", aes_block_in, 128'hA0A1A2A3A4A5A6A7A8A9AAABAC000000);
        wait_drain();
        repeat (2) @(negedge clk);

        // Stray done while idle in COLLECT.
        stray_req++;
        repeat (3) @(negedge clk);
        check_val("stray_busy", busy, 0);
        check_val("stray_in_ready", in_ready, 1);
        check_val("stray_out_valid", out_valid, 0);
        check_val("stray_out_block", out_block, last_exp_blk);
        check_val("stray_count", blk_count, exp_blocks % (1 << TB_CNT_W));

        // Reset while waiting on the core with a byte of the next stream pending.
        aes_lat = 30;
        queue_stream(16, 1'b0, -1, 1'b0);
        drive_tx(1'b0);
        repeat (5) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        check_val("wait_busy", busy, 1);
        check_val("wait_in_ready", in_ready, 0);
        check_val("wait_out_valid", out_valid, 0);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_in_ready", in_ready, 0);
        check_val("mid_rst_aes_start", aes_start, 0);
        check_val("mid_rst_aes_block_in", aes_block_in, 0);
        check_val("mid_rst_out_block", out_block, 0);
        check_val("mid_rst_out_valid", out_valid, 0);
        check_val("mid_rst_blk_count", blk_count, 0);
        check_val("mid_rst_busy", busy, 0);
        exp_blocks = 0;
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        aes_lat = 10;
        queue_stream(16, 1'b0, -1, 1'b1);
        drive_tx(1'b0);
        check_val("post_rst_start", aes_start, 1);
        wait_drain();
        @(negedge clk);
        check_val("post_rst_count", blk_count, 1);

        // Randomized streams, gaps, random downstream stalls and core latency.
        sink_rand = 1'b1;
        lat_rand  = 1'b1;
        for (int s = 0; s < 30; s++) begin
            if ($urandom_range(0, 2) == 0) begin
                n = 16 * $urandom_range(1, 2);
                lst = 1'b0;
            end else begin
                n = $urandom_range(1, 40);
                lst = 1'b1;
            end
            queue_stream(n, lst, -1, 1'b1);
            drive_tx(1'b1);
        end
        wait_drain();

        // Back-to-back full blocks with the sink always ready.
        sink_rand  = 1'b0;
        sink_force = 1'b1;
        lat_rand   = 1'b0;
        aes_lat    = 1;
        queue_stream(16 * 40, 1'b0, -1, 1'b1);
        drive_tx(1'b0);
        wait_drain();
        repeat (2) @(negedge clk);
        check_val("final_blk_count", blk_count, exp_blocks % (1 << TB_CNT_W));
        check_val("final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
